// File: rtl/c499_key_ctrl.sv
// Key-programming controller for the logic-locked c499 core: serial key load,
// golden-vector self-check, functional-path gating and lockout after repeated failures.
module c499_key_ctrl #(
  parameter int          KEY_W      = 28,
  parameter int          SETTLE_CYC = 2,
  parameter int          MAX_FAIL   = 3,
  parameter logic [40:0] GOLD_IN    = 41'h0_0000_0000_1,
  parameter logic [31:0] GOLD_OUT   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        key_sin,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [3:0]  key_mux,
  output logic [23:0] key_xor,
  input  logic [40:0] func_in,
  output logic [40:0] core_in,
  input  logic [31:0] core_out,
  output logic        busy,
  output logic        key_ok,
  output logic        key_fail,
  output logic        locked_out
);

  typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, COMPARE, PASS, FAIL, LOCK} state_t;

  state_t             state;
  logic [KEY_W-1:0]   sr;
  logic [KEY_W-1:0]   sr_nxt;
  logic [4:0]         bit_cnt;
  logic [3:0]         settle_cnt;
  logic [2:0]         fail_cnt;
  logic [2:0]         fail_nxt;

  assign sr_nxt   = {sr[KEY_W-2:0], key_sin};
  assign fail_nxt = fail_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      fail_cnt   <= '0;
      key_mux    <= '0;
      key_xor    <= '0;
      key_ok     <= 1'b0;
      key_fail   <= 1'b0;
      locked_out <= 1'b0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (load_start) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            key_ok    <= 1'b0;
            key_fail  <= 1'b0;
            key_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (key_valid) begin
            sr      <= sr_nxt;
            bit_cnt <= bit_cnt + 5'd1;
            // final bit goes straight to the key pins, bypassing sr
            if (bit_cnt == 5'(KEY_W-1)) begin
              key_mux    <= sr_nxt[27:24];
              key_xor    <= sr_nxt[23:0];
              settle_cnt <= '0;
              key_ready  <= 1'b0;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == 4'(SETTLE_CYC-1)) state <= COMPARE;
        end
        COMPARE: begin
          busy <= 1'b0;
          if (core_out == GOLD_OUT) begin
            key_ok   <= 1'b1;
            fail_cnt <= '0;
            state    <= PASS;
          end else begin
            key_fail <= 1'b1;
            fail_cnt <= fail_nxt;
            if (fail_nxt == 3'(MAX_FAIL)) begin
              locked_out <= 1'b1;
              key_mux    <= '0;
              key_xor    <= '0;
              state      <= LOCK;
            end else begin
              state <= FAIL;
            end
          end
        end
        LOCK: begin
          locked_out <= 1'b1;
          key_fail   <= 1'b1;
          key_mux    <= '0;
          key_xor    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // functional data reaches the core only once the key has been proven
  always_comb begin
    core_in = '0;
    case (state)
      SETTLE, COMPARE: core_in = GOLD_IN;
      PASS:            core_in = func_in;
      default:         core_in = '0;
    endcase
  end

endmodule

// File: tb/tb_c499_key_ctrl.sv
// Randomized self-checking bench for c499_key_ctrl with a behavioural locked-core
// model and a transaction-level model of pass/fail/lockout bookkeeping.
module tb_c499_key_ctrl;
  localparam int          SETTLE_CYC = 2;
  localparam int          MAX_FAIL   = 3;
  localparam logic [40:0] GOLD_IN    = 41'h0_0000_0000_1;
  localparam logic [31:0] GOLD_OUT   = 32'h0000_0001;
  localparam logic [27:0] GOOD_KEY   = 28'hA5C396E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0, key_sin = 1'b0, key_valid = 1'b0;
  logic        key_ready, busy, key_ok, key_fail, locked_out;
  logic [3:0]  key_mux;
  logic [23:0] key_xor;
  logic [40:0] func_in = '0, core_in;
  logic [31:0] core_out;

  int vectors = 0, miscompares = 0;
  int m_fails = 0;
  bit m_locked = 1'b0;

  c499_key_ctrl #(.KEY_W(28), .SETTLE_CYC(SETTLE_CYC), .MAX_FAIL(MAX_FAIL),
                  .GOLD_IN(GOLD_IN), .GOLD_OUT(GOLD_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_sin(key_sin),
    .key_valid(key_valid), .key_ready(key_ready), .key_mux(key_mux),
    .key_xor(key_xor), .func_in(func_in), .core_in(core_in),
    .core_out(core_out), .busy(busy), .key_ok(key_ok), .key_fail(key_fail),
    .locked_out(locked_out));

  always #5 clk = ~clk;

  // locked core: golden response only for the right key and golden stimulus
  always_comb
    core_out = (core_in == GOLD_IN && {key_mux, key_xor} == GOOD_KEY) ? GOLD_OUT : 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mux"},   64'(key_mux), 0);
    chk({tag, "_xor"},   64'(key_xor), 0);
    chk({tag, "_flags"}, 64'({key_ok, key_fail, locked_out, key_ready, busy}), 0);
    chk({tag, "_core"},  64'(core_in), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk_reset_vals("reset");
    m_fails = 0; m_locked = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // mode 0: valid held high, 1: toggling, 2: random gaps (plus ignored load_start noise)
  task automatic load_key(input logic [27:0] key, input int mode);
    int acc = 0, cyc = 0, n = 0;
    bit v, pass;
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("ready_rise", 64'({key_ready, busy}), 64'b11);
    while (acc < 28 && cyc < 500) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      key_valid  = v;
      key_sin    = key[27-acc];
      load_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("ready_shift", 64'(key_ready), 1);
      tick(); cyc++;
      if (v) acc++;
    end
    key_valid = 1'b0; load_start = 1'b0;
    chk("shift_done", 64'(acc), 28);
    if (mode == 1) chk("toggle_cycles", 64'(cyc), 55);
    chk("key_pins", 64'({key_mux, key_xor}), 64'(key));
    chk("ready_fall", 64'({key_ready, busy}), 64'b01);
    while (!(key_ok | key_fail) && n < 20) begin
      chk("gold_in", 64'(core_in), 64'(GOLD_IN));
      tick(); n++;
    end
    chk("latency", 64'(n), 64'(SETTLE_CYC + 1));
    pass = (key == GOOD_KEY);
    if (pass) m_fails = 0; else m_fails++;
    m_locked = (m_fails >= MAX_FAIL);
    chk("result", 64'({key_ok, key_fail, locked_out}), 64'({pass, !pass, m_locked}));
    chk("idle_flags", 64'({busy, key_ready}), 0);
    chk("key_hold", 64'({key_mux, key_xor}), m_locked ? 64'h0 : 64'(key));
    func_in = {9'($urandom), $urandom};
    #1;
    chk("core_in", 64'(core_in), pass ? 64'(func_in) : 64'h0);
  endtask

  function automatic logic [27:0] bad_key();
    logic [27:0] d;
    d = 28'($urandom);
    if (d == 0) d = 28'h1;
    return GOOD_KEY ^ d;
  endfunction

  initial begin
    int acc;
    do_reset();
    // correct key, continuous valid; functional pass-through
    load_key(GOOD_KEY, 0);
    func_in = 41'h155_5555_5555; #1;
    chk("func_pass", 64'(core_in), 64'(41'h155_5555_5555));
    // X_1 flipped
    load_key(GOOD_KEY ^ 28'h1, 0);
    // two more failures reach lockout
    load_key(bad_key(), 2);
    load_key(bad_key(), 0);
    chk("locked", 64'(locked_out), 1);
    load_start = 1'b1; tick(); load_start = 1'b0;
    repeat (3) begin
      chk("lock_no_ready", 64'({key_ready, busy, locked_out, key_fail}), 64'b0011);
      tick();
    end
    do_reset();
    // toggling valid
    load_key(GOOD_KEY, 1);
    // asynchronous reset mid-shift after 13 bits
    load_start = 1'b1; tick(); load_start = 1'b0;
    acc = 0;
    key_valid = 1'b1;
    while (acc < 13) begin key_sin = GOOD_KEY[27-acc]; tick(); acc++; end
    key_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk_reset_vals("midshift_rst");
    m_fails = 0; m_locked = 1'b0;
    tick(); rst_n = 1'b1; tick();
    load_key(GOOD_KEY, 2);
    // fail count cleared by a pass
    load_key(bad_key(), 0);
    load_key(bad_key(), 2);
    load_key(GOOD_KEY, 0);
    load_key(bad_key(), 1);
    load_key(bad_key(), 0);
    chk("no_lock_after_pass", 64'(locked_out), 0);
    // random traffic
    repeat (12) begin
      if (m_locked) do_reset();
      if ($urandom_range(0, 1) == 1) load_key(GOOD_KEY, 32'($urandom_range(0, 2)));
      else load_key(bad_key(), 32'($urandom_range(0, 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
